// File: rtl/cpu_pkg.sv
// Shared datapath/controller definitions: control-word bit positions,
// PC source encodings and instruction field offsets.
package cpu_pkg;

    localparam int unsigned CW_WIDTH        = 17;
    localparam int unsigned CW_PCWRITECOND  = 16;
    localparam int unsigned CW_PCWRITE      = 15;
    localparam int unsigned CW_IORD         = 14;
    localparam int unsigned CW_MEMREAD      = 13;
    localparam int unsigned CW_MEMWRITE     = 12;
    localparam int unsigned CW_MEMTOREG     = 11;
    localparam int unsigned CW_IRWRITE      = 10;
    localparam int unsigned CW_PCSOURCE_HI  = 9;
    localparam int unsigned CW_PCSOURCE_LO  = 8;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pc_src_e;

    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 26;
    localparam int unsigned JTGT_HI = 25;

    localparam logic [5:0] OPC_NOOP = 6'b000000;

endpackage

// File: rtl/pc_ir_unit_pc_next_sel.sv
// Next-PC selection and PC write enable (PCWrite has priority over the
// branch-not-equal condition).
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [31:0]      i_pc,
    input  logic [JTGT_HI:0] i_ir_target,
    input  logic [31:0]      i_aluout,
    input  logic [31:0]      i_alu_result,
    input  pc_src_e          i_pc_source,
    input  logic             i_pc_write,
    input  logic             i_pc_write_cond,
    input  logic             i_alu_zero,
    output logic [31:0]      o_next_pc,
    output logic             o_pc_en
);

    always_comb begin
        o_next_pc = i_pc;
        unique case (i_pc_source)
            PCSRC_ALU:    o_next_pc = i_alu_result;
            PCSRC_ALUOUT: o_next_pc = i_aluout;
            PCSRC_JUMP:   o_next_pc = {i_pc[OPC_HI:OPC_LO], i_ir_target};
            PCSRC_HOLD:   o_next_pc = i_pc;
        endcase
    end

    assign o_pc_en = i_pc_write | (i_pc_write_cond & ~i_alu_zero);

endmodule

// File: rtl/pc_ir_unit.sv
// Multicycle datapath front end: PC, IR, MDR and ALUOut registers.
// Define PC_IR_INSTR_COUNT_EN to build the fetched-instruction counter.
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CW_WIDTH-1:0] ctrl_word,
    input  logic [31:0]         mem_rdata,
    input  logic [31:0]         alu_result,
    input  logic                alu_zero,
    output logic [5:0]          opcode,
    output logic [31:0]         ir,
    output logic [31:0]         pc,
    output logic [31:0]         mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [31:0]         aluout,
    output logic [31:0]         mdr,
    output logic [31:0]         instr_count
);

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_aluout;
    logic [31:0] r_mdr;
    logic [31:0] w_next_pc;
    logic        w_pc_en;
    logic        w_ir_write;
    logic        w_mem_read;
    pc_src_e     w_pc_source;

    // MemtoReg and the ALU/register-file fields are consumed elsewhere.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{ctrl_word[CW_MEMTOREG], ctrl_word[7:0]};

    assign w_ir_write  = ctrl_word[CW_IRWRITE];
    assign w_mem_read  = ctrl_word[CW_MEMREAD];
    assign w_pc_source = pc_src_e'(ctrl_word[CW_PCSOURCE_HI:CW_PCSOURCE_LO]);

    pc_next_sel u_pc_next_sel (
        .i_pc            (r_pc),
        .i_ir_target     (r_ir[JTGT_HI:0]),
        .i_aluout        (r_aluout),
        .i_alu_result    (alu_result),
        .i_pc_source     (w_pc_source),
        .i_pc_write      (ctrl_word[CW_PCWRITE]),
        .i_pc_write_cond (ctrl_word[CW_PCWRITECOND]),
        .i_alu_zero      (alu_zero),
        .o_next_pc       (w_next_pc),
        .o_pc_en         (w_pc_en)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            r_aluout <= alu_result;
            if (w_ir_write) r_ir <= mem_rdata;
            if (w_mem_read && !w_ir_write) r_mdr <= mem_rdata;
            if (w_pc_en) r_pc <= w_next_pc;
        end
    end

`ifdef PC_IR_INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (w_ir_write && (mem_rdata[OPC_HI:OPC_LO] != OPC_NOOP)) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = '0;
`endif

    assign pc       = r_pc;
    assign ir       = r_ir;
    assign aluout   = r_aluout;
    assign mdr      = r_mdr;
    assign opcode   = r_ir[OPC_HI:OPC_LO];
    assign mem_addr = ctrl_word[CW_IORD] ? r_aluout : r_pc;
    assign mem_rd   = w_mem_read;
    assign mem_wr   = ctrl_word[CW_MEMWRITE];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: directed scenarios then random cycles,
// checked against a behavioural model of the register-transfer rules.
module tb_pc_ir_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0010;

    localparam logic [16:0] B_PWC = 17'h1_0000;
    localparam logic [16:0] B_PW  = 17'h0_8000;
    localparam logic [16:0] B_IOD = 17'h0_4000;
    localparam logic [16:0] B_MR  = 17'h0_2000;
    localparam logic [16:0] B_IRW = 17'h0_0400;
    localparam logic [16:0] S_ALUOUT = 17'h0_0100;
    localparam logic [16:0] S_JUMP   = 17'h0_0200;

`ifdef PC_IR_INSTR_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] ctrl_word;
    logic [31:0] mem_rdata;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [5:0]  opcode;
    logic [31:0] ir, pc, mem_addr, aluout, mdr, instr_count;
    logic        mem_rd, mem_wr;

    pc_ir_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_word   (ctrl_word),
        .mem_rdata   (mem_rdata),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .opcode      (opcode),
        .ir          (ir),
        .pc          (pc),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .aluout      (aluout),
        .mdr         (mdr),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [5:0]  opc;
    } comb_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] aluout;
        logic [31:0] mdr;
        logic [31:0] cnt;
    } state_t;

    comb_t  comb_q[$];
    state_t st_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    // Reference state
    state_t m;
    bit     m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input logic [16:0] cw, input logic [31:0] rdata,
                         input logic [31:0] alur, input bit zero);
        comb_t  c;
        state_t n;
        bit     irw, take;
        logic [31:0] tgt;
        @(negedge clk);
        reset      = rst;
        ctrl_word  = cw;
        mem_rdata  = rdata;
        alu_result = alur;
        alu_zero   = zero;
        if (m_valid) begin
            c.addr = cw[14] ? m.aluout : m.pc;
            c.rd   = cw[13];
            c.wr   = cw[12];
            c.opc  = m.ir[31:26];
            comb_q.push_back(c);
        end
        n = m;
        if (rst) begin
            n.pc = RST_PC; n.ir = 0; n.aluout = 0; n.mdr = 0; n.cnt = 0;
        end else begin
            irw = cw[10];
            n.aluout = alur;
            if (irw) n.ir = rdata;
            if (cw[13] && !irw) n.mdr = rdata;
            case (cw[9:8])
                2'd0:    tgt = alur;
                2'd1:    tgt = m.aluout;
                2'd2:    tgt = (m.pc & 32'hFC00_0000) | (m.ir & 32'h03FF_FFFF);
                default: tgt = m.pc;
            endcase
            take = cw[15] || (cw[16] && !zero);
            if (take) n.pc = tgt;
            if (COUNT_EN && irw && (rdata[31:26] != 0)) n.cnt = m.cnt + 1;
        end
        if (m_valid || rst) begin
            st_q.push_back(n);
            m = n;
            m_valid = 1'b1;
        end
    endtask

    // Monitor: combinational outputs after the negedge drive, registers after posedge.
    initial begin : monitor
        comb_t  c;
        state_t s;
        while (!done) begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                chk("mem_addr", mem_addr, c.addr);
                chk("mem_rd", {31'd0, mem_rd}, {31'd0, c.rd});
                chk("mem_wr", {31'd0, mem_wr}, {31'd0, c.wr});
                chk("opcode", {26'd0, opcode}, {26'd0, c.opc});
            end
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("pc", pc, s.pc);
                chk("ir", ir, s.ir);
                chk("aluout", aluout, s.aluout);
                chk("mdr", mdr, s.mdr);
                chk("instr_count", instr_count, s.cnt);
            end
        end
    end

    initial begin : driver
        reset = 1'b1; ctrl_word = '0; mem_rdata = '0; alu_result = '0; alu_zero = 1'b0;
        // Reset, then idle to observe reset values
        cycle(1, 17'd0, 32'd0, 32'd0, 0);
        cycle(0, 17'd0, 32'd0, 32'd0, 0);
        // Move pc to 0, then fetch-and-increment
        cycle(0, B_PW, 32'd0, 32'd0, 0);
        cycle(0, B_PW | B_IRW | B_MR, 32'h4822_0000, 32'd1, 0);
        cycle(0, 17'd0, 32'd0, 32'h40, 0);
        // BNE taken, then not taken
        cycle(0, B_PWC | S_ALUOUT, 32'd0, 32'h44, 0);
        cycle(0, B_PWC | S_ALUOUT, 32'd0, 32'h99, 1);
        // PCWrite overrides the condition even with zero set
        cycle(0, 17'd0, 32'd0, 32'h80, 0);
        cycle(0, B_PW | B_PWC | S_ALUOUT, 32'd0, 32'd0, 1);
        // Jump
        cycle(0, B_PW | B_IRW, 32'h0400_0123, 32'h0400_0005, 0);
        cycle(0, B_PW | S_JUMP, 32'd0, 32'h20, 0);
        // Load via aluout address
        cycle(0, B_IOD | B_MR, 32'hDEAD_BEEF, 32'd0, 0);
        cycle(0, 17'd0, 32'd0, 32'd0, 0);
        // NOOP fetch does not count
        cycle(0, B_IRW, 32'h0000_1234, 32'd0, 0);
        // Wrap-around value from ALU
        cycle(0, B_PW, 32'd0, 32'hFFFF_FFFF, 0);
        cycle(0, B_PW, 32'd0, 32'h0, 0);
        // Reset beats write enables mid-instruction
        cycle(0, B_IRW, 32'hFC00_0000, 32'd0, 0);
        cycle(1, B_PW | B_IRW | B_MR, 32'h8C00_0001, 32'h77, 0);
        cycle(0, 17'd0, 32'd0, 32'd0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 29) == 0), 17'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 1) == 1));
        end
        cycle(0, 17'd0, 32'd0, 32'd0, 0);
        repeat (3) @(posedge clk);
        n_checks++;
        if (comb_q.size() != 0 || st_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", comb_q.size(), st_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have port ctrl_word  input  17  controller control word: [16] PCWriteCond, [15] PCWrite, [14] IorD, [13] MemRead, [12] MemWrite, [11] MemtoReg, [10] IRWrite, [9:8] PCSource, [7:5] ALUOp, [4:3] ALUSrcB, [2] ALUSrcA, [1] RegWrite, [0] RegDst.
REQ-005 SHALL have port mem_rdata  input  32  memory read data.
REQ-006 SHALL have port alu_result  input  32  combinational ALU output.
REQ-007 SHALL have port alu_zero  input  1  ALU result-is-zero flag.
REQ-008 SHALL have port opcode  output  6  IR[31:26]; drives the controller's input_signal.
REQ-009 SHALL have port ir  output  32  instruction register.
REQ-010 SHALL have port pc  output  32  program counter.
REQ-011 SHALL have port mem_addr  output  32  memory address.
REQ-012 SHALL have port mem_rd, mem_wr  output  1 each  memory strobes.
REQ-013 SHALL have ports aluout, mdr  output  32 each  ALUOut and memory-data registers.
REQ-014 SHALL have port instr_count  output  32  fetched-instruction count (see Configuration).

Function
REQ-015 SHALL drive mem_addr = IorD ? aluout : pc, combinationally.
REQ-016 SHALL drive mem_rd = MemRead and mem_wr = MemWrite, combinationally; mem_rd and mem_wr both 1 is passed through unchanged.
REQ-017 SHALL load ir <= mem_rdata at a posedge where IRWrite=1; otherwise ir holds.
REQ-018 SHALL load mdr <= mem_rdata at every posedge where MemRead=1 and IRWrite=0.
REQ-019 SHALL load aluout <= alu_result at every posedge (not reset).
REQ-020 SHALL select next_pc by PCSource: 00 alu_result; 01 aluout; 10 {pc[31:26], ir[25:0]}; 11 pc (hold).
REQ-021 SHALL write pc <= next_pc when PCWrite=1, or when PCWriteCond=1 and alu_zero=0 (BNE taken); otherwise pc holds.
REQ-022 SHALL give PCWrite=1 priority: with PCWrite=1 and PCWriteCond=1, pc is written regardless of alu_zero.
REQ-023 SHALL, when IRWrite and a pc write coincide, latch ir from the current mem_addr and update pc in the same edge (fetch-and-increment, latency 1 cycle).
REQ-024 SHALL drive opcode = ir[31:26] combinationally, so the new opcode is visible the cycle after IRWrite.
REQ-025 SHALL treat ctrl_word bits [11], [7:0] as don't-care (consumed by the ALU/register file).
REQ-026 SHALL wrap PC arithmetic modulo 2^32; 32'hFFFF_FFFF + 1 from the ALU yields 0 with no flag.

Reset
REQ-027 SHALL, on reset=1 at a posedge, set pc=RESET_PC, ir=0 (opcode NOOP), aluout=0, mdr=0, instr_count=0.
REQ-028 SHALL give reset priority over every ctrl_word write enable in the same cycle, including mid-instruction.

Configuration
REQ-029 SHALL, with PC_IR_INSTR_COUNT_EN defined, increment instr_count by 1 (wrapping at 2^32) at every non-reset posedge with IRWrite=1 and mem_rdata[31:26] != 6'b000000.
REQ-030 SHALL, without PC_IR_INSTR_COUNT_EN, tie instr_count to 0 and synthesise no counter.

Structure
REQ-031 SHALL take the control-word bit positions, PCSource encodings, opcode field offsets and the NOOP opcode constant from shared package cpu_pkg, shared with the controller.
REQ-032 SHALL implement next-PC selection and the write-enable logic (REQ-020..022) in one sub-module, pc_next_sel.

Verification
REQ-033 Reset with RESET_PC=32'h10 -> pc=0x10, ir=0, opcode=0, instr_count=0.
REQ-034 Fetch: pc=0, mem_rdata=0x4822_0000, IRWrite=1, PCWrite=1, PCSource=00, alu_result=1 -> next cycle ir=0x4822_0000, opcode=6'b010010, pc=1, instr_count=1.
REQ-035 BNE: aluout=0x40, PCWriteCond=1, PCSource=01, alu_zero=0 -> pc=0x40; repeat with alu_zero=1 -> pc unchanged.
REQ-036 Jump: pc=0x0400_0005, ir=0x0400_0123, PCWrite=1, PCSource=10 -> pc=0x0400_0123.
REQ-037 LWI: IorD=1, MemRead=1, aluout=0x20, mem_rdata=0xDEAD_BEEF -> mem_addr=0x20, mem_rd=1, next cycle mdr=0xDEAD_BEEF, ir unchanged.
REQ-038 Reset asserted with PCWrite=1, IRWrite=1 -> pc=RESET_PC, ir=0, instr_count not incremented.
